flght_mixer: RTL and testbench

//  Consumer end of the PD-term interface: takes pitch/roll/yaw pterm/dterm from three PD_math

---
 rtl/flght_mixer.sv | 209 ++++++++++++++++++++
 tb/tb_flght_mixer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flght_mixer.sv
// -----------------------------------------------------------------------------
// flght_mixer
//   Mixes pitch/roll/yaw PD terms and pilot thrust into four saturated motor
//   speed commands. One shared multi-operand adder is time-multiplexed by a
//   small FSM: IDLE -> AXIS (3 cycles) -> MIX (4 cycles) -> UPD (1 cycle).
//   A capture on edge N updates all four outputs together on edge N+8, and
//   spd_vld pulses for the cycle after that edge.
//
//   Optional feature macro: SLEW_LIMIT_EN
//     defined   : each output moves toward its target by at most SLEW_MAX per
//                 update (calibration speed still loads directly).
//     undefined : outputs load the saturated targets directly.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   vld                        PD terms valid (sampled only in IDLE)
//   thrst[8:0]                 unsigned pilot thrust
//   ptch/roll/yaw_pterm[9:0]   signed P terms
//   ptch/roll/yaw_dterm[11:0]  signed D terms
//   inertial_cal               calibration mode: all speeds forced to CAL_SPD
//   frnt/bck/lft/rght_spd[10:0] unsigned motor speeds
//   spd_vld                    one-cycle pulse after all four speeds update
//   busy                       high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module flght_mixer #(
  parameter logic [10:0] MIN_RUN  = 11'h1A0,
  parameter logic [10:0] CAL_SPD  = 11'h1B0,
  parameter logic [10:0] SLEW_MAX = 11'd64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vld,
  input  logic [8:0]  thrst,
  input  logic [9:0]  ptch_pterm,
  input  logic [11:0] ptch_dterm,
  input  logic [9:0]  roll_pterm,
  input  logic [11:0] roll_dterm,
  input  logic [9:0]  yaw_pterm,
  input  logic [11:0] yaw_dterm,
  input  logic        inertial_cal,
  output logic [10:0] frnt_spd,
  output logic [10:0] bck_spd,
  output logic [10:0] lft_spd,
  output logic [10:0] rght_spd,
  output logic        spd_vld,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, AXIS, MIX, UPD} state_t;

  state_t      state_q, state_d;
  logic [1:0]  step_q, step_d;      // axis / motor index within AXIS and MIX

  // Captured inputs
  logic [8:0]  thrst_q;
  logic [9:0]  ptch_p_q, roll_p_q, yaw_p_q;
  logic [11:0] ptch_d_q, roll_d_q, yaw_d_q;
  logic        cal_q;

  // Per-axis sums and per-motor staging (index 0..3 = front, back, left, right)
  logic signed [12:0] ptch_q, roll_q, yaw_q;
  logic        [10:0] stage_q [4];
  logic        [10:0] out_q   [4];
  logic               spd_vld_q;

  // Shared adder operands and result
  logic signed [14:0] op_a, op_b, op_c, op_d;
  logic signed [14:0] sum;
  logic        [10:0] sat;

  // ---------------------------------------------------------------------------
  // FSM: state register + next-state logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    state_d = state_q;
    busy    = (state_q != IDLE);
    unique case (state_q)
      IDLE: if (vld)           state_d = AXIS;
      AXIS: if (step_q == 2'd2) state_d = MIX;
      MIX:  if (step_q == 2'd3) state_d = UPD;
      UPD:                     state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
    step_d = (state_q == IDLE || state_d != state_q) ? 2'd0 : step_q + 2'd1;
  end

  // ---------------------------------------------------------------------------
  // Shared adder. AXIS: pterm + dterm. MIX: MIN_RUN + thrst +/- axis +/- yaw.
  // ---------------------------------------------------------------------------
  always_comb begin
    op_a = '0;
    op_b = '0;
    op_c = '0;
    op_d = '0;
    if (state_q == AXIS) begin
      unique case (step_q)
        2'd0:    begin op_a = 15'(signed'(ptch_p_q)); op_b = 15'(signed'(ptch_d_q)); end
        2'd1:    begin op_a = 15'(signed'(roll_p_q)); op_b = 15'(signed'(roll_d_q)); end
        default: begin op_a = 15'(signed'(yaw_p_q));  op_b = 15'(signed'(yaw_d_q));  end
      endcase
    end else if (state_q == MIX) begin
      op_a = signed'({4'b0, MIN_RUN});
      op_b = signed'({6'b0, thrst_q});
      unique case (step_q)
        2'd0:    begin op_c = -15'(ptch_q); op_d = -15'(yaw_q); end  // front
        2'd1:    begin op_c =  15'(ptch_q); op_d = -15'(yaw_q); end  // back
        2'd2:    begin op_c = -15'(roll_q); op_d =  15'(yaw_q); end  // left
        default: begin op_c =  15'(roll_q); op_d =  15'(yaw_q); end  // right
      endcase
    end
    sum = op_a + op_b + op_c + op_d;
    // Saturate to 11-bit unsigned: negative -> 0, above 2047 -> all ones.
    if (sum[14])              sat = 11'h000;
    else if (sum[13:11] != 0) sat = 11'h7FF;
    else                      sat = sum[10:0];
  end

`ifdef SLEW_LIMIT_EN
  // Step from cur toward tgt by at most SLEW_MAX; cur+SLEW_MAX cannot exceed
  // tgt (<= 2047) when that branch is taken, so no overflow.
  function automatic logic [10:0] slew(input logic [10:0] cur, input logic [10:0] tgt);
    logic signed [11:0] diff;
    diff = signed'({1'b0, tgt}) - signed'({1'b0, cur});
    if (diff > signed'({1'b0, SLEW_MAX}))       return cur + SLEW_MAX;
    else if (diff < -signed'({1'b0, SLEW_MAX})) return cur - SLEW_MAX;
    else                                        return tgt;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thrst_q   <= '0;
      ptch_p_q  <= '0;
      roll_p_q  <= '0;
      yaw_p_q   <= '0;
      ptch_d_q  <= '0;
      roll_d_q  <= '0;
      yaw_d_q   <= '0;
      cal_q     <= 1'b0;
      ptch_q    <= '0;
      roll_q    <= '0;
      yaw_q     <= '0;
      spd_vld_q <= 1'b0;
      // NOTE: these small register arrays are reset explicitly because reset
      // must drive the outputs (and staging) to 0; a RAM-style array would not.
      for (int i = 0; i < 4; i++) begin
        stage_q[i] <= '0;
        out_q[i]   <= '0;
      end
    end else begin
      spd_vld_q <= (state_q == UPD);
      unique case (state_q)
        IDLE: if (vld) begin
          thrst_q  <= thrst;
          ptch_p_q <= ptch_pterm;
          ptch_d_q <= ptch_dterm;
          roll_p_q <= roll_pterm;
          roll_d_q <= roll_dterm;
          yaw_p_q  <= yaw_pterm;
          yaw_d_q  <= yaw_dterm;
          cal_q    <= inertial_cal;
        end
        AXIS: begin
          unique case (step_q)
            2'd0:    ptch_q <= sum[12:0];
            2'd1:    roll_q <= sum[12:0];
            default: yaw_q  <= sum[12:0];
          endcase
        end
        MIX: stage_q[step_q] <= sat;
        UPD: begin
          for (int i = 0; i < 4; i++) begin
            if (cal_q) out_q[i] <= CAL_SPD;
`ifdef SLEW_LIMIT_EN
            else       out_q[i] <= slew(out_q[i], stage_q[i]);
`else
            else       out_q[i] <= stage_q[i];
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign frnt_spd = out_q[0];
  assign bck_spd  = out_q[1];
  assign lft_spd  = out_q[2];
  assign rght_spd = out_q[3];
  assign spd_vld  = spd_vld_q;

endmodule

// File: tb/tb_flght_mixer.sv
// -----------------------------------------------------------------------------
// tb_flght_mixer
//   Self-checking bench for flght_mixer. A behavioural model (integer mixing
//   equations plus a countdown for the 8-edge latency) predicts every output;
//   a compare process checks the DUT against it on each falling edge. Directed
//   cases pin the model with hand-computed literals; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_flght_mixer;

  localparam int MIN_RUN  = 'h1A0;
  localparam int CAL_SPD  = 'h1B0;
  localparam int SLEW_MAX = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld = 1'b0;
  logic [8:0]  thrst = '0;
  logic [9:0]  ptch_pterm = '0, roll_pterm = '0, yaw_pterm = '0;
  logic [11:0] ptch_dterm = '0, roll_dterm = '0, yaw_dterm = '0;
  logic        inertial_cal = 1'b0;
  logic [10:0] frnt_spd, bck_spd, lft_spd, rght_spd;
  logic        spd_vld, busy;

  int checks   = 0;
  int failures = 0;

  flght_mixer dut (
    .clk(clk), .rst_n(rst_n), .vld(vld), .thrst(thrst),
    .ptch_pterm(ptch_pterm), .ptch_dterm(ptch_dterm),
    .roll_pterm(roll_pterm), .roll_dterm(roll_dterm),
    .yaw_pterm(yaw_pterm), .yaw_dterm(yaw_dterm),
    .inertial_cal(inertial_cal),
    .frnt_spd(frnt_spd), .bck_spd(bck_spd), .lft_spd(lft_spd), .rght_spd(rght_spd),
    .spd_vld(spd_vld), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int m_cnt;          // edges remaining until outputs update (0 = idle)
  int m_out [4];
  int m_tgt [4];
  bit m_cal;
  bit m_vld;

  function automatic int sat11(input int v);
    if (v < 0)    return 0;
    if (v > 2047) return 2047;
    return v;
  endfunction

  function automatic int step_to(input int cur, input int tgt);
`ifdef SLEW_LIMIT_EN
    if (tgt > cur + SLEW_MAX) return cur + SLEW_MAX;
    if (tgt < cur - SLEW_MAX) return cur - SLEW_MAX;
`endif
    return tgt;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0;
      m_cal = 0;
      m_vld = 0;
      for (int i = 0; i < 4; i++) begin m_out[i] = 0; m_tgt[i] = 0; end
    end else begin
      m_vld = 0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          for (int i = 0; i < 4; i++) m_out[i] = m_cal ? CAL_SPD : step_to(m_out[i], m_tgt[i]);
          m_vld = 1;
        end
      end else if (vld) begin
        int p, r, y, base;
        p    = $signed(ptch_pterm) + $signed(ptch_dterm);
        r    = $signed(roll_pterm) + $signed(roll_dterm);
        y    = $signed(yaw_pterm)  + $signed(yaw_dterm);
        base = MIN_RUN + int'(thrst);
        m_tgt[0] = sat11(base - p - y);
        m_tgt[1] = sat11(base + p - y);
        m_tgt[2] = sat11(base - r + y);
        m_tgt[3] = sat11(base + r + y);
        m_cal = inertial_cal;
        m_cnt = 8;
      end
    end
  end

  // Compare process: every falling edge, DUT against model.
  always @(negedge clk) begin
    check("frnt_spd", int'(frnt_spd), m_out[0]);
    check("bck_spd",  int'(bck_spd),  m_out[1]);
    check("lft_spd",  int'(lft_spd),  m_out[2]);
    check("rght_spd", int'(rght_spd), m_out[3]);
    check("spd_vld",  int'(spd_vld),  int'(m_vld));
    check("busy",     int'(busy),     int'(m_cnt != 0));
  end

  // ---------------------------------------------------------------------------
  // Directed helpers
  // ---------------------------------------------------------------------------
  task automatic set_terms(input logic [8:0] t,
                           input logic [9:0] pp, input logic [11:0] pd,
                           input logic [9:0] rp, input logic [11:0] rd,
                           input logic [9:0] yp, input logic [11:0] yd,
                           input logic cal);
    thrst = t; ptch_pterm = pp; ptch_dterm = pd; roll_pterm = rp; roll_dterm = rd;
    yaw_pterm = yp; yaw_dterm = yd; inertial_cal = cal;
  endtask

  // Pulse vld from an idle DUT and wait for spd_vld; lat = edges after capture.
  task automatic pulse_and_wait(output int lat);
    int n;
    n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end
    vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    n = 1;
    while (!spd_vld && n < 20) begin @(negedge clk); n++; end
    lat = n - 1;
  endtask

  int lat;
  int pulses;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_frnt", int'(frnt_spd), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_vld",  int'(spd_vld), 0);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef SLEW_LIMIT_EN
    // Case 6: ramp from 0 toward 0x2A0 in 64-count steps.
    set_terms(9'h100, '0, '0, '0, '0, '0, '0, 1'b0);
    for (int k = 1; k <= 11; k++) begin
      pulse_and_wait(lat);
      check("slew_latency", lat, 8);
      check("slew_frnt", int'(frnt_spd), (k * 64 < 'h2A0) ? k * 64 : 'h2A0);
      check("slew_rght", int'(rght_spd), (k * 64 < 'h2A0) ? k * 64 : 'h2A0);
    end
`else
    // Case 1: zero terms, thrust 0x100.
    set_terms(9'h100, '0, '0, '0, '0, '0, '0, 1'b0);
    pulse_and_wait(lat);
    check("c1_latency", lat, 8);
    check("c1_frnt", int'(frnt_spd), 'h2A0);
    check("c1_bck",  int'(bck_spd),  'h2A0);
    check("c1_lft",  int'(lft_spd),  'h2A0);
    check("c1_rght", int'(rght_spd), 'h2A0);
    @(negedge clk);
    check("c1_vld_one_cycle", int'(spd_vld), 0);

    // Case 2: pitch only.
    set_terms(9'h100, 10'h010, 12'h004, '0, '0, '0, '0, 1'b0);
    pulse_and_wait(lat);
    check("c2_frnt", int'(frnt_spd), 'h28C);
    check("c2_bck",  int'(bck_spd),  'h2B4);
    check("c2_lft",  int'(lft_spd),  'h2A0);
    check("c2_rght", int'(rght_spd), 'h2A0);

    // Case 3: saturation at both ends.
    set_terms(9'h1FF, '0, '0, 10'h1FF, 12'h7FF, '0, '0, 1'b0);
    pulse_and_wait(lat);
    check("c3_rght", int'(rght_spd), 'h7FF);
    check("c3_lft",  int'(lft_spd),  'h000);
    check("c3_frnt", int'(frnt_spd), 'h39F);

    // Case 4: calibration, plus a second vld while busy that must be dropped.
    set_terms(9'h0AB, 10'h123, 12'h456, 10'h301, 12'h9AB, 10'h055, 12'hF00, 1'b1);
    vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    repeat (3) @(negedge clk);
    set_terms(9'h010, '0, '0, '0, '0, '0, '0, 1'b0);
    vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      if (spd_vld) pulses++;
      @(negedge clk);
    end
    check("c4_pulses", pulses, 1);
    check("c4_frnt", int'(frnt_spd), 'h1B0);
    check("c4_rght", int'(rght_spd), 'h1B0);
`endif

    // Case 5: reset asserted during MIX aborts and clears at once.
    set_terms(9'h100, 10'h010, 12'h004, '0, '0, '0, '0, 1'b0);
    vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("c5_rst_frnt", int'(frnt_spd), 0);
    check("c5_rst_bck",  int'(bck_spd),  0);
    check("c5_rst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_terms(9'h100, '0, '0, '0, '0, '0, '0, 1'b0);
    pulse_and_wait(lat);
    check("c5_after_latency", lat, 8);
`ifndef SLEW_LIMIT_EN
    check("c5_after_frnt", int'(frnt_spd), 'h2A0);
`else
    check("c5_after_frnt", int'(frnt_spd), 'h040);
`endif

    // Randomized phase: inputs change every cycle, vld asserted ~1/3 of cycles.
    for (int i = 0; i < 1500; i++) begin
      thrst        = 9'($urandom);
      ptch_pterm   = 10'($urandom);
      ptch_dterm   = 12'($urandom);
      roll_pterm   = 10'($urandom);
      roll_dterm   = 12'($urandom);
      yaw_pterm    = 10'($urandom);
      yaw_dterm    = 12'($urandom);
      inertial_cal = ($urandom_range(0, 7) == 0);
      vld          = ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end
    vld = 1'b0;
    repeat (12) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
